// File: rtl/div_pkg.sv
// Shared definitions for the iterative 32-bit divider: FSM encodings,
// handshake levels and the two's-complement helper.
package div_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    localparam logic [5:0] DivIterations = 6'd32;

    function automatic logic [31:0] neg32(input logic [31:0] value);
        return ~value + 32'd1;
    endfunction

endpackage

// File: rtl/div.sv
// Radix-2 restoring divider, 32 iterations, result held until start_i drops.
// Signed division is built only when DIV_SIGNED_EN is defined.
module div
    import div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    div_state_e  state_r;
    logic [5:0]  cnt_r;
    logic [64:0] work_r;
    logic [31:0] divisor_r;
    logic [32:0] diff_s;
    logic [31:0] op1_mag_s;
    logic [31:0] op2_mag_s;
    logic [31:0] quo_s;
    logic [31:0] rem_s;

`ifdef DIV_SIGNED_EN
    logic sign1_r;
    logic sign2_r;
    logic signed_r;

    // Operand magnitudes and result sign correction for signed mode
    always_comb begin
        op1_mag_s = opdata1_i;
        op2_mag_s = opdata2_i;
        quo_s     = work_r[31:0];
        rem_s     = work_r[64:33];
        if (signed_div_i && opdata1_i[31]) begin
            op1_mag_s = neg32(opdata1_i);
        end else begin
            op1_mag_s = opdata1_i;
        end
        if (signed_div_i && opdata2_i[31]) begin
            op2_mag_s = neg32(opdata2_i);
        end else begin
            op2_mag_s = opdata2_i;
        end
        if (signed_r && (sign1_r ^ sign2_r)) begin
            quo_s = neg32(work_r[31:0]);
        end else begin
            quo_s = work_r[31:0];
        end
        if (signed_r && sign1_r) begin
            rem_s = neg32(work_r[64:33]);
        end else begin
            rem_s = work_r[64:33];
        end
    end
`else
    logic unused_signed_s;
    assign unused_signed_s = signed_div_i;

    // Unsigned-only build: operands and results pass straight through
    always_comb begin
        op1_mag_s = opdata1_i;
        op2_mag_s = opdata2_i;
        quo_s     = work_r[31:0];
        rem_s     = work_r[64:33];
    end
`endif

    // Trial subtraction; bit 32 set means the divisor did not fit
    assign diff_s = {1'b0, work_r[63:32]} - {1'b0, divisor_r};

    // Divider FSM with registered result and ready
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= DivFree;
            cnt_r     <= 6'd0;
            work_r    <= 65'd0;
            divisor_r <= 32'd0;
            result_o  <= 64'd0;
            ready_o   <= DivResultNotReady;
`ifdef DIV_SIGNED_EN
            sign1_r   <= 1'b0;
            sign2_r   <= 1'b0;
            signed_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                DivFree: begin
                    if (start_i == DivStart && !annul_i) begin
                        if (opdata2_i == 32'd0) begin
                            state_r <= DivByZero;
                        end else begin
                            state_r   <= DivOn;
                            cnt_r     <= 6'd0;
                            work_r    <= {32'd0, op1_mag_s, 1'b0};
                            divisor_r <= op2_mag_s;
`ifdef DIV_SIGNED_EN
                            sign1_r   <= signed_div_i & opdata1_i[31];
                            sign2_r   <= signed_div_i & opdata2_i[31];
                            signed_r  <= signed_div_i;
`endif
                        end
                    end else begin
                        state_r <= DivFree;
                    end
                end
                DivByZero: begin
                    result_o <= 64'd0;
                    ready_o  <= DivResultReady;
                    state_r  <= DivEnd;
                end
                DivOn: begin
                    if (annul_i) begin
                        state_r <= DivFree;
                    end else if (cnt_r != DivIterations) begin
                        if (diff_s[32]) begin
                            work_r <= {work_r[63:0], 1'b0};
                        end else begin
                            work_r <= {diff_s[31:0], work_r[31:0], 1'b1};
                        end
                        cnt_r <= cnt_r + 6'd1;
                    end else begin
                        result_o <= {rem_s, quo_s};
                        ready_o  <= DivResultReady;
                        state_r  <= DivEnd;
                    end
                end
                DivEnd: begin
                    if (start_i == DivStop) begin
                        result_o <= 64'd0;
                        ready_o  <= DivResultNotReady;
                        state_r  <= DivFree;
                    end else begin
                        state_r <= DivEnd;
                    end
                end
                default: begin
                    state_r <= DivFree;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed corner cases plus randomized
// divisions against a plain-arithmetic reference model.
module tb_div;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_cmp;
    int n_err;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: {remainder, quotient} from the language's own division
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
`ifdef DIV_SIGNED_EN
        if (sgn) begin
            sa = $signed({{32{a[31]}}, a});
            sb = $signed({{32{b[31]}}, b});
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
`endif
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Counts edges until ready_o, optionally scrambling operands after capture
    task automatic wait_ready(input bit scramble, output int edges, output bit got, output bit leak);
        edges = 0;
        got   = 1'b0;
        leak  = 1'b0;
        while (!got && edges < 60) begin
            @(posedge clk);
            #1;
            edges++;
            if (scramble) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = 1'($urandom);
            end
            if (ready_o) got = 1'b1;
            else if (result_o != 64'd0) leak = 1'b1;
        end
    endtask

    task automatic finish_op(input string tag, input logic [63:0] exp);
        @(posedge clk);
        #1;
        check({tag, "_hold_rdy"}, 64'(ready_o), 64'd1);
        check({tag, "_hold_res"}, result_o, exp);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_clr_rdy"}, 64'(ready_o), 64'd0);
        check({tag, "_clr_res"}, result_o, 64'd0);
    endtask

    task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
        int edges;
        bit got, leak;
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        wait_ready(1'b1, edges, got, leak);
        check({tag, "_lat"}, 64'(edges), (b == 32'd0) ? 64'd2 : 64'd34);
        check({tag, "_idle"}, 64'(leak), 64'd0);
        check({tag, "_res"}, result_o, exp);
        if (got) finish_op(tag, exp);
        else begin
            @(negedge clk);
            start_i = 1'b0;
            repeat (40) @(posedge clk);
        end
    endtask

    initial begin
        int edges;
        bit got, leak, seen;
        logic [31:0] a, b;
        logic sgn;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i = 32'd0;
        opdata2_i = 32'd0;
        start_i = 1'b0;
        annul_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy", 64'(ready_o), 64'd0);
        check("rst_res", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        do_div("u100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
`ifdef DIV_SIGNED_EN
        do_div("s_m100_7", 1'b1, 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2);
        do_div("s_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
`else
        do_div("s_m100_7", 1'b1, 32'hFFFFFF9C, 32'd7, 64'h00000002_24924916);
        do_div("s_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000);
`endif
        do_div("umax_1", 1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF);
        do_div("div0", 1'b0, 32'd5, 32'd0, 64'd0);

        // Annul in FREE suppresses acceptance for that edge
        @(negedge clk);
        opdata1_i = 32'd5;
        opdata2_i = 32'd0;
        start_i   = 1'b1;
        annul_i   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        annul_i = 1'b0;
        wait_ready(1'b0, edges, got, leak);
        check("annul_free_lat", 64'(edges), 64'd2);
        if (got) finish_op("annul_free", 64'd0);

        // Annul during ON: back to FREE, no result ever
        @(negedge clk);
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        start_i   = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready_o || result_o != 64'd0) seen = 1'b1;
        end
        check("annul_on_quiet", 64'(seen), 64'd0);
        do_div("after_annul", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003);

        // Reset mid-ON, then start accepted on first edge after reset
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_rdy", 64'(ready_o), 64'd0);
        check("midrst_res", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_ready(1'b0, edges, got, leak);
        check("postrst_lat", 64'(edges), 64'd34);
        check("postrst_res", result_o, 64'h00000006_0000008E);
        if (got) finish_op("postrst", 64'h00000006_0000008E);

        // Randomized divisions against the reference model
        for (int i = 0; i < 24; i++) begin
            sgn = 1'($urandom);
            a   = $urandom;
            case ($urandom_range(3, 0))
                0: b = 32'd0;
                1: b = 32'($urandom_range(15, 1));
                2: b = {$urandom} | 32'h80000000;
                default: b = $urandom;
            endcase
            if ((i % 5) == 0) a = 32'h80000000;
            do_div($sformatf("rnd%0d", i), sgn, a, b, ref_div(sgn, a, b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
